shift_reg_ctrl: RTL

SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

---
 rtl/shift_reg_pkg.sv | 33 +++
 rtl/universal_shift_reg16.sv | 34 +++
 rtl/shift_reg_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared opcodes, register modes, FSM states and size defaults
package shift_reg_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_ROR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    // ROR is a right shift whose fill comes from the register itself
    function automatic mode_e shift_mode(op_e op);
        return (op == OP_SHL) ? MODE_SHL : MODE_SHR;
    endfunction

endpackage

// File: rtl/universal_shift_reg16.sv
// universal_shift_reg16: hold / shift right / shift left / parallel load register
module universal_shift_reg16
    import shift_reg_pkg::*;
#(
    parameter int W = WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  mode_e        mode,
    input  logic [W-1:0] d,
    input  logic         sin_left,
    input  logic         sin_right,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // sin_right enters the MSB on a right shift, sin_left enters the LSB on a left shift
    always_comb begin
        q_d = (mode == MODE_LOAD) ? d :
              (mode == MODE_SHR)  ? {sin_right, q_q[W-1:1]} :
              (mode == MODE_SHL)  ? {q_q[W-2:0], sin_left} : q_q;
    end

    // register update
    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: command FSM that sequences loads and multi-step shifts of a universal shift register
module shift_reg_ctrl
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             fill_q, fill_d;
    mode_e            mode;
    logic             sin_right;

    // next-state, command latch and step counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        fill_d  = fill_q;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                op_d    = op_e'(cmd_op);
                cnt_d   = cmd_count;
                data_d  = cmd_data;
                fill_d  = cmd_fill;
                state_d = (op_e'(cmd_op) == OP_LOAD) ? S_LOAD :
                          (cmd_count == '0)          ? S_DONE : S_SHIFT;
            end
            S_LOAD:  state_d = S_DONE;
            S_SHIFT: begin
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_SHIFT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // controller state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
        end
    end

    // register mode and serial input derived from the current state and latched command
    always_comb begin
        mode      = (state_q == S_LOAD)  ? MODE_LOAD :
                    (state_q == S_SHIFT) ? shift_mode(op_q) : MODE_HOLD;
        sin_right = (op_q == OP_ROR) ? q[0] : fill_q;
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign done      = (state_q == S_DONE);

    universal_shift_reg16 #(.W(WIDTH)) u_sreg (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .d         (data_q),
        .sin_left  (fill_q),
        .sin_right (sin_right),
        .q         (q)
    );

endmodule
